// File: rtl/da_pkg.sv
// Shared constants for the DA serial transmitter: sample/frame widths,
// TLC5615 interface timing and FSM state encodings.
package da_pkg;

   localparam int DA_DATA_W     = 10;
   localparam int DA_FRAME_BITS = 12;

   // TLC5615 timing in CLK_50M cycles: SCLK half-period and CS_N high time
   localparam int DA_CLK_DIV    = 2;
   localparam int DA_CS_GAP     = 4;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SETUP = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_GAP   = 2'd3;

endpackage

// File: rtl/da_serial_tx.sv
// Shifts each captured DA sample MSB-first into a TLC5615-style DAC as a
// 12-bit frame; a one-deep pending buffer absorbs a start that arrives mid-frame.
module da_serial_tx
   import da_pkg::*;
#(
   parameter int DATA_W     = DA_DATA_W,
   parameter int FRAME_BITS = DA_FRAME_BITS,
   parameter int CLK_DIV    = DA_CLK_DIV,
   parameter int CS_GAP     = DA_CS_GAP
) (
   input  logic              CLK_50M,
   input  logic              RST_N,
   input  logic [DATA_W-1:0] da_data,
   input  logic              da_start,
   output logic              DA_CS_N,
   output logic              DA_SCLK,
   output logic              DA_DIN,
   output logic              da_busy,
   output logic              da_done,
   output logic              da_overrun
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
   localparam int PAD_W = FRAME_BITS - DATA_W;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);
   localparam logic [3:0]       BIT_LAST = 4'(FRAME_BITS - 1);

   logic [1:0]            r_state;
   logic [DIV_W-1:0]      r_div_cnt;
   logic [3:0]            r_bit_cnt;
   logic [GAP_W-1:0]      r_gap_cnt;
   logic [FRAME_BITS-1:0] r_shreg;
   logic                  r_pend_valid;
   logic [DATA_W-1:0]     r_pend_data;
   logic                  r_cs_n;
   logic                  r_sclk;
   logic                  r_din;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_overrun;

   logic                  w_div_end;
   logic                  w_gap_end;
   logic                  w_load;
   logic                  w_load_pend;
   logic [DATA_W-1:0]     w_load_data;
   logic [FRAME_BITS-1:0] w_shreg_shl;

   assign w_div_end   = (r_div_cnt == DIV_LAST);
   assign w_gap_end   = (r_state == ST_GAP) && (r_gap_cnt == GAP_LAST);
   assign w_load_pend = w_gap_end && r_pend_valid;
   assign w_load_data = w_load_pend ? r_pend_data : da_data;
   assign w_load      = ((r_state == ST_IDLE) && da_start) ||
                        (w_gap_end && (r_pend_valid || da_start));
   assign w_shreg_shl = r_shreg << 1;

   always_ff @(posedge CLK_50M or negedge RST_N) begin
      if (!RST_N) begin
         r_state      <= ST_IDLE;
         r_div_cnt    <= '0;
         r_bit_cnt    <= '0;
         r_gap_cnt    <= '0;
         r_shreg      <= '0;
         r_pend_valid <= 1'b0;
         r_pend_data  <= '0;
         r_cs_n       <= 1'b1;
         r_sclk       <= 1'b0;
         r_din        <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_done    <= 1'b0;
         r_overrun <= 1'b0;

         // On the last GAP cycle an empty buffer is bypassed: the start loads directly
         if (da_start && (r_state != ST_IDLE)) begin
            if (r_pend_valid) begin
               r_overrun <= 1'b1;
            end else if (!w_gap_end) begin
               r_pend_valid <= 1'b1;
               r_pend_data  <= da_data;
            end
         end

         if (w_load) begin
            r_state   <= ST_SETUP;
            r_shreg   <= {w_load_data, {PAD_W{1'b0}}};
            r_cs_n    <= 1'b0;
            r_sclk    <= 1'b0;
            r_din     <= w_load_data[DATA_W-1];
            r_div_cnt <= '0;
            r_busy    <= 1'b1;
            if (w_load_pend) begin
               r_pend_valid <= 1'b0;
            end
         end else begin
            case (r_state)
               ST_IDLE: begin
               end
               ST_SETUP: begin
                  if (w_div_end) begin
                     r_state   <= ST_SHIFT;
                     r_sclk    <= 1'b1;
                     r_div_cnt <= '0;
                     r_bit_cnt <= '0;
                  end else begin
                     r_div_cnt <= r_div_cnt + DIV_W'(1);
                  end
               end
               ST_SHIFT: begin
                  if (!w_div_end) begin
                     r_div_cnt <= r_div_cnt + DIV_W'(1);
                  end else begin
                     r_div_cnt <= '0;
                     // r_sclk doubles as the half-bit phase flag
                     if (r_sclk) begin
                        r_sclk  <= 1'b0;
                        r_shreg <= w_shreg_shl;
                        r_din   <= w_shreg_shl[FRAME_BITS-1];
                     end else if (r_bit_cnt == BIT_LAST) begin
                        r_state   <= ST_GAP;
                        r_cs_n    <= 1'b1;
                        r_din     <= 1'b0;
                        r_done    <= 1'b1;
                        r_gap_cnt <= '0;
                     end else begin
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        r_sclk    <= 1'b1;
                     end
                  end
               end
               ST_GAP: begin
                  if (w_gap_end) begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_cs_n  <= 1'b1;
                  r_sclk  <= 1'b0;
                  r_din   <= 1'b0;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign DA_CS_N    = r_cs_n;
   assign DA_SCLK    = r_sclk;
   assign DA_DIN     = r_din;
   assign da_busy    = r_busy;
   assign da_done    = r_done;
   assign da_overrun = r_overrun;

endmodule

// File: tb/tb_da_serial_tx.sv
// Bench for da_serial_tx: directed starts feed an expected-word queue; a DAC-side
// monitor rebuilds each frame from CS_N/SCLK/DIN and checks it against the queue.
module tb_da_serial_tx;

   logic       CLK_50M = 1'b0;
   logic       RST_N = 1'b0;
   logic [9:0] da_data = '0;
   logic       da_start = 1'b0;
   logic       DA_CS_N;
   logic       DA_SCLK;
   logic       DA_DIN;
   logic       da_busy;
   logic       da_done;
   logic       da_overrun;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int n_done = 0;
   int n_ovr = 0;
   int n_frames = 0;
   int sb[$];
   int fall_q[$];
   int rise_q[$];
   int ovr_q[$];

   da_serial_tx dut (
      .CLK_50M    (CLK_50M),
      .RST_N      (RST_N),
      .da_data    (da_data),
      .da_start   (da_start),
      .DA_CS_N    (DA_CS_N),
      .DA_SCLK    (DA_SCLK),
      .DA_DIN     (DA_DIN),
      .da_busy    (da_busy),
      .da_done    (da_done),
      .da_overrun (da_overrun)
   );

   always #10 CLK_50M = ~CLK_50M;
   always @(posedge CLK_50M) cyc <= cyc + 1;

   task automatic check(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   // DAC model: sample DIN on SCLK rising edges while CS_N is low
   initial begin
      logic prev_cs = 1'b1;
      logic prev_sclk = 1'b0;
      int   bits = 0;
      int   low_len = 0;
      int   word = 0;
      int   exp_w;
      forever begin
         @(negedge CLK_50M);
         if (!RST_N) begin
            prev_cs = 1'b1;
            prev_sclk = 1'b0;
            bits = 0;
            low_len = 0;
            word = 0;
         end else begin
            if (prev_cs && !DA_CS_N) begin
               fall_q.push_back(cyc);
               bits = 0;
               low_len = 0;
               word = 0;
            end
            if (!DA_CS_N) low_len++;
            if (!DA_CS_N && !prev_sclk && DA_SCLK) begin
               word = ((word << 1) | int'(DA_DIN)) & 12'hFFF;
               bits++;
               if (bits == 1) rise_q.push_back(cyc);
            end
            if (da_done || (!prev_cs && DA_CS_N))
               check("done_at_cs_rise", int'(da_done), int'(!prev_cs && DA_CS_N));
            if (!prev_cs && DA_CS_N) begin
               n_frames++;
               $display("frame %0d word=0x%03h bits=%0d cs_low=%0d at cyc %0d",
                        n_frames, word, bits, low_len, cyc);
               check("sclk_rises", bits, 12);
               check("cs_low_len", low_len, 50);
               if (sb.size() == 0) begin
                  check("unexpected_frame", word, -1);
               end else begin
                  exp_w = sb.pop_front();
                  check("frame_word", word, exp_w);
               end
            end
            if (da_done) n_done++;
            if (da_overrun) begin
               n_ovr++;
               ovr_q.push_back(cyc);
            end
            prev_cs = DA_CS_N;
            prev_sclk = DA_SCLK;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK_50M);
         #1;
      end
   endtask

   task automatic start(input logic [9:0] d, input bit expect_frame, output int t);
      da_data = d;
      da_start = 1'b1;
      t = cyc;
      if (expect_frame) sb.push_back(int'({d, 2'b00}));
      @(posedge CLK_50M);
      #1;
      da_start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      @(negedge CLK_50M);
      while (da_busy && k < budget) begin
         @(negedge CLK_50M);
         k++;
      end
      check("idle_timeout", int'(da_busy), 0);
      @(posedge CLK_50M);
      #1;
   endtask

   function automatic logic [9:0] rom(input int i);
      return 10'((i * 389 + 17) % 1024);
   endfunction

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, t1, t2, d0;

      // Reset values
      repeat (3) @(posedge CLK_50M);
      @(negedge CLK_50M);
      check("rst_cs_n", int'(DA_CS_N), 1);
      check("rst_sclk", int'(DA_SCLK), 0);
      check("rst_din", int'(DA_DIN), 0);
      check("rst_busy", int'(da_busy), 0);
      check("rst_done", int'(da_done), 0);
      check("rst_ovr", int'(da_overrun), 0);
      @(posedge CLK_50M);
      #1;
      RST_N = 1'b1;
      tick(2);

      // Reset mid-SHIFT with a sample waiting in the pending buffer
      start(10'h2AA, 1'b1, t0);
      tick(4);
      start(10'h1C3, 1'b1, t1);
      tick(10);
      #3;
      RST_N = 1'b0;
      @(negedge CLK_50M);
      check("midrst_cs_n", int'(DA_CS_N), 1);
      check("midrst_sclk", int'(DA_SCLK), 0);
      check("midrst_din", int'(DA_DIN), 0);
      check("midrst_busy", int'(da_busy), 0);
      sb.delete();
      @(posedge CLK_50M);
      #1;
      RST_N = 1'b1;
      tick(2);
      start(10'h0AA, 1'b1, t0);
      wait_idle(300);
      tick(5);
      check("midrst_no_stale_frame", sb.size(), 0);

      // Full-scale sample: FFC on the wire, one done pulse
      d0 = n_done;
      start(10'h3FF, 1'b1, t0);
      wait_idle(200);
      check("fullscale_done_cnt", n_done - d0, 1);

      // Alternating pattern; first SCLK rise 3 cycles after the strobe
      rise_q.delete();
      start(10'h155, 1'b1, t0);
      wait_idle(200);
      check("first_rise_lat", (rise_q.size() > 0) ? rise_q[0] - t0 : -1, 3);

      // Second start 10 cycles later waits in pending; next CS_N fall at 55
      fall_q.delete();
      d0 = n_ovr;
      start(10'h001, 1'b1, t0);
      tick(9);
      start(10'h200, 1'b1, t1);
      wait_idle(300);
      check("b2b_frames", fall_q.size(), 2);
      check("b2b_second_fall", (fall_q.size() > 1) ? fall_q[1] - t0 : -1, 55);
      check("b2b_no_ovr", n_ovr - d0, 0);

      // Third start while pending is full is dropped; registered pulse one cycle later
      ovr_q.delete();
      d0 = n_ovr;
      start(10'h0F0, 1'b1, t0);
      tick(4);
      start(10'h30F, 1'b1, t1);
      tick(3);
      start(10'h2AB, 1'b0, t2);
      wait_idle(300);
      check("ovr_cnt", n_ovr - d0, 1);
      check("ovr_lat", (ovr_q.size() > 0) ? ovr_q[0] - t2 : -1, 1);

      // Start on the last GAP cycle goes straight to SETUP
      fall_q.delete();
      start(10'h0C5, 1'b1, t0);
      tick(53);
      start(10'h33A, 1'b1, t1);
      wait_idle(300);
      check("gap_last_frames", fall_q.size(), 2);
      check("gap_last_fall", (fall_q.size() > 1) ? fall_q[1] - t0 : -1, 55);

      // Generator cadence of 97 cycles
      d0 = n_ovr;
      for (int i = 0; i < 256; i++) begin
         start(rom(i), 1'b1, t0);
         tick(96);
      end
      wait_idle(300);
      check("cadence_no_ovr", n_ovr - d0, 0);
      check("sb_leftover", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
